// File: rtl/eq2_sweep_checker_amisha_if.sv
// Stimulus/response bundle between the sweep checker
// and the 2-bit equality comparator it exercises.
interface eq2_sweep_checker_amisha_if #(
  parameter int WIDTH = 2
);
  logic               start_amisha;
  logic               aeqb_amisha;
  logic [WIDTH-1:0]   a_amisha;
  logic [WIDTH-1:0]   b_amisha;
  logic               busy_amisha;
  logic               done_amisha;
  logic               pass_amisha;
  logic [2*WIDTH:0]   err_count_amisha;
  logic [WIDTH-1:0]   fail_a_amisha;
  logic [WIDTH-1:0]   fail_b_amisha;

  modport master (
    input  start_amisha,
    input  aeqb_amisha,
    output a_amisha,
    output b_amisha,
    output busy_amisha,
    output done_amisha,
    output pass_amisha,
    output err_count_amisha,
    output fail_a_amisha,
    output fail_b_amisha
  );

  modport slave (
    output start_amisha,
    output aeqb_amisha,
    input  a_amisha,
    input  b_amisha,
    input  busy_amisha,
    input  done_amisha,
    input  pass_amisha,
    input  err_count_amisha,
    input  fail_a_amisha,
    input  fail_b_amisha
  );
endinterface

// File: rtl/eq2_sweep_checker_amisha.sv
// Built-in self-test sweep for the eq2 comparator:
// walks every {a,b}, checks aeqb, logs errors.
module eq2_sweep_checker_amisha #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  eq2_sweep_checker_amisha_if.master bus
);
  localparam int IW = 2 * WIDTH;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic [IW:0]    err_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic           seen_q;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic           mismatch;
  logic [IW:0]    err_nxt;

  assign cur_a = idx[IW-1:WIDTH];
  assign cur_b = idx[WIDTH-1:0];

  // Compare the sampled result to the ideal a==b.
  always_comb begin
    mismatch = 1'b0;
    err_nxt  = err_q;
    mismatch = (bus.aeqb_amisha != (cur_a == cur_b));
    err_nxt  = err_q + {{IW{1'b0}}, mismatch};
  end

  // Sweep sequencer with registered status outputs.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start_amisha) begin
            state    <= S_SETTLE;
            idx      <= '0;
            cnt      <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            seen_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_q <= err_nxt;
            if (!seen_q) begin
              fail_a_q <= cur_a;
              fail_b_q <= cur_b;
              seen_q   <= 1'b1;
            end
          end
          if (idx == '1) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            pass_q <= (err_nxt == '0);
            idx    <= '0;
          end else begin
            idx   <= idx + IW'(1);
            cnt   <= '0;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_amisha         = cur_a;
  assign bus.b_amisha         = cur_b;
  assign bus.busy_amisha      = busy_q;
  assign bus.done_amisha      = done_q;
  assign bus.pass_amisha      = pass_q;
  assign bus.err_count_amisha = err_q;
  assign bus.fail_a_amisha    = fail_a_q;
  assign bus.fail_b_amisha    = fail_b_q;
endmodule
